// File: rtl/seq_link_pkg.sv
// seq_link_pkg: one-hot state encoding and counter-width helper shared by seq_link_ctrl.
package seq_link_pkg;
  typedef enum logic [3:0] {
    IDLE      = 4'b0001,
    ESTABLISH = 4'b0010,
    RANDOMIZE = 4'b0100,
    DONE      = 4'b1000
  } state_e;
  localparam int MIN_CNT_W = 1;
  // Bits needed to hold 0..max_val, never narrower than one bit.
  function automatic int cnt_w(input int max_val);
    return (max_val < 1) ? MIN_CNT_W : $clog2(max_val + 1);
  endfunction
endpackage

// File: rtl/seq_link_ctrl_cycle_counter.sv
// cycle_counter: saturating up-counter with synchronous clear and terminal-value compare.
module cycle_counter #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic         hit
);
  logic [W-1:0] cnt;
  always_ff @(posedge clk)
    cnt <= clr ? '0 : (en && cnt != '1) ? cnt + W'(1) : cnt;
  assign hit = cnt == term;
endmodule

// File: rtl/seq_link_ctrl.sv
// seq_link_ctrl: captures a frame request, runs preamble establishment, then a bounded or free-running randomization phase.
module seq_link_ctrl
  import seq_link_pkg::*;
#(
  parameter int DATA_W        = 32,
  parameter int NUM_W         = 8,
  parameter int LEN_W         = 16,
  parameter int PREAMBLE_REPS = 2,
  parameter int TIMEOUT_CYC   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] in,
  input  logic [NUM_W-1:0]  n,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              data_valid,
  output logic              data_ready,
  input  logic              seq_done,
  input  logic              abort,
  output logic              seq_enable,
  output logic              rand_flag,
  output logic [NUM_W-1:0]  seq_num,
  output logic [DATA_W-1:0] seq_data,
  output logic              busy,
  output logic              frame_done,
  output logic              timeout_err
);
  localparam int REP_W = cnt_w(PREAMBLE_REPS);
  localparam int TMO_W = cnt_w(TIMEOUT_CYC);
  state_e state, state_n;
  logic [LEN_W-1:0] len_q;
  logic [REP_W-1:0] rep_cnt;
  logic tmo_hit, len_hit, rep_last, tmo_fire, accept;
  assign data_ready = state == IDLE;
  assign seq_enable = state == ESTABLISH;
  assign rand_flag  = state == RANDOMIZE;
  assign busy       = state != IDLE;
  assign frame_done = state == DONE;
  assign accept     = state == IDLE && data_valid;
  assign rep_last   = rep_cnt == REP_W'(PREAMBLE_REPS - 1);
  // seq_done and abort both outrank the timeout.
  assign tmo_fire   = state == ESTABLISH && !abort && !seq_done && TIMEOUT_CYC != 0 && tmo_hit;
  cycle_counter #(.W(TMO_W)) u_tmo (
    .clk  (clk),
    .clr  (rst || state != ESTABLISH || seq_done),
    .en   (state == ESTABLISH),
    .term (TMO_W'(TIMEOUT_CYC - 1)),
    .hit  (tmo_hit)
  );
  cycle_counter #(.W(LEN_W)) u_len (
    .clk  (clk),
    .clr  (rst || state != RANDOMIZE),
    .en   (state == RANDOMIZE),
    .term (len_q - LEN_W'(1)),
    .hit  (len_hit)
  );
  always_comb begin
    state_n = IDLE;
    case (state)
      IDLE:      state_n = data_valid ? ESTABLISH : IDLE;
      ESTABLISH: state_n = abort ? IDLE : (seq_done && rep_last) ? RANDOMIZE : tmo_fire ? IDLE : ESTABLISH;
      RANDOMIZE: state_n = abort ? IDLE : (len_q != '0 && len_hit) ? DONE : RANDOMIZE;
      default:   state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      seq_data    <= '0;
      seq_num     <= '0;
      len_q       <= '0;
      rep_cnt     <= '0;
      timeout_err <= 1'b0;
    end else begin
      state       <= state_n;
      timeout_err <= tmo_fire;
      rep_cnt     <= state != ESTABLISH ? '0 : (seq_done && rep_cnt != '1) ? rep_cnt + REP_W'(1) : rep_cnt;
      if (accept) begin
        seq_data <= in;
        seq_num  <= n;
        len_q    <= frame_len;
      end
    end
  end
endmodule

// File: doc/seq_link_ctrl.md
Name: seq_link_ctrl

Overview:
- Parametrised link controller. Accepts one frame request (seed data, sequence number, frame length) via a valid/ready handshake.
- Runs an establishment phase that repeats the preamble pattern N times on the sequence generator. Then asserts the randomization phase for a bounded or free-running number of cycles.
- Sits between the frame source and the preamble sequence generator / randomizer.
- Adds over the previous generation: input capture, preamble repeat count, establishment timeout, frame length with return to IDLE, and abort.

Parameters:
- DATA_W, 32: width of seed data.
- NUM_W, 8: width of sequence number.
- LEN_W, 16: width of frame length, in randomization cycles.
- PREAMBLE_REPS, 2: seq_done pulses required to leave ESTABLISH. Legal range is 1 or more.
- TIMEOUT_CYC, 64: maximum cycles between seq_done pulses in ESTABLISH. 0 disables the timeout.

Ports:
- clk, in, 1: clock, rising edge.
- rst, in, 1: reset, synchronous, active-high.
- in, in, DATA_W: seed data.
- n, in, NUM_W: sequence number.
- frame_len, in, LEN_W: randomization length. 0 means free-running until abort.
- data_valid, in, 1: request valid.
- data_ready, out, 1: request accepted when data_valid && data_ready.
- seq_done, in, 1: one-cycle pulse; preamble repetition complete.
- abort, in, 1: terminate current frame.
- seq_enable, out, 1: drive preamble generator.
- rand_flag, out, 1: randomization active.
- seq_num, out, NUM_W: captured n.
- seq_data, out, DATA_W: captured in.
- busy, out, 1: state is not IDLE.
- frame_done, out, 1: one-cycle pulse at normal frame completion.
- timeout_err, out, 1: one-cycle pulse on establishment timeout.

Behaviour:
- Single clock domain.
- Reset: rst is synchronous and active-high, sampled on the rising edge of clk. On the first edge with rst high:
  - state goes to IDLE;
  - seq_data, seq_num, and all counters go to 0;
  - frame_done and timeout_err go to 0.
  - This state yields seq_enable=0, rand_flag=0, busy=0, data_ready=1.
- Reset mid-frame: same result, with no frame_done or timeout_err pulse.
- FSM states are one-hot: IDLE, ESTABLISH, RANDOMIZE, DONE.
- seq_enable, rand_flag, busy and data_ready are decoded from state only. They have no combinational path from inputs.
- IDLE:
  - data_ready=1.
  - On data_valid at edge T: capture in, n and frame_len; clear the counters; next state is ESTABLISH.
  - seq_enable is 1 from T+1.
  - abort and seq_done are ignored in IDLE.
- ESTABLISH:
  - seq_enable=1, held continuously across repetitions; data_ready=0.
  - Each seq_done increments rep_cnt and clears tmo_cnt.
  - When seq_done arrives with rep_cnt==PREAMBLE_REPS-1, next state is RANDOMIZE.
  - Otherwise tmo_cnt increments each cycle.
  - If TIMEOUT_CYC!=0 and tmo_cnt==TIMEOUT_CYC-1 without seq_done: next state is IDLE and timeout_err pulses for 1 cycle.
  - If seq_done and the timeout occur in the same cycle, seq_done wins.
- RANDOMIZE:
  - rand_flag=1; seq_enable=0.
  - len_cnt increments each cycle.
  - If the captured len!=0 and len_cnt==len-1: next state is DONE. rand_flag is therefore high for exactly len cycles.
  - If len==0: stay in RANDOMIZE until abort.
  - seq_done is ignored.
- DONE:
  - Lasts 1 cycle; frame_done=1; all other strobes are 0.
  - Next state is IDLE, so a new request is accepted at the earliest 2 cycles after the last rand_flag.
- abort:
  - In ESTABLISH, RANDOMIZE or DONE: next state is IDLE.
  - Abort has priority over seq_done, timeout and length completion.
  - No frame_done and no timeout_err are generated on abort.
- seq_data and seq_num:
  - Registered; they hold their value until the next accepted request, including after completion or abort.
  - in and n have no effect outside acceptance.
- Counter widths and wrap:
  - rep_cnt: $clog2(PREAMBLE_REPS+1).
  - tmo_cnt: $clog2(TIMEOUT_CYC+1).
  - len_cnt: LEN_W.
  - No counter wraps; each is cleared on every state entry.
- Illegal state (not one-hot): next state is IDLE.

Decomposition:
- Package seq_link_pkg holds:
  - the state_e one-hot enum (IDLE=4'b0001, ESTABLISH=4'b0010, RANDOMIZE=4'b0100, DONE=4'b1000);
  - localparam helpers for counter widths.
- One sub-module: cycle_counter (parameter W).
  - Inputs: clr, en, terminal value. Output: hit.
  - Instantiated for both the timeout and the frame length counters.
- rep_cnt stays inline.

Test Plan:
1. Reset, then data_valid=1 with in=32'hDEADBEEF, n=8'h5A, frame_len=4.
   - seq_enable is high from the next cycle.
   - seq_done pulses at +5 and +10 lead to rand_flag high for exactly 4 cycles.
   - frame_done then pulses once; state returns to IDLE.
   - seq_data=32'hDEADBEEF and seq_num=8'h5A are held throughout and after.
2. Accept, then one seq_done, then none for 64 cycles.
   - timeout_err pulses on the 64th cycle after that seq_done.
   - State returns to IDLE; data_ready=1; rand_flag never asserts.
3. frame_len=0 with 2 seq_done pulses.
   - rand_flag stays high for 200+ cycles.
   - abort at cycle 200 drops rand_flag on the next cycle; no frame_done.
4. seq_done, abort and the timeout terminal all in the same cycle in ESTABLISH.
   - Next state is IDLE; no pulses are generated.
   - Separately, seq_done on the timeout terminal cycle advances rep_cnt with no timeout_err.
5. rst asserted during RANDOMIZE with len=10 at cycle 3.
   - Next cycle: rand_flag=0, seq_data=0, seq_num=0, busy=0, no frame_done.
   - data_valid held during rst is not accepted.
6. Back-to-back requests with data_valid held high.
   - The second request is captured exactly 1 cycle after the frame_done cycle.
   - data_ready is 0 throughout the first frame.
